seq_sm_multiplier: RTL and testbench
====================================

Name: seq_sm_multiplier

Overview:
- Parametrised sequential sign-magnitude multiplier for the ALU datapath. It replaces the fixed 4-bit combinational multiply with an operand width set by parameter.
- Computes the product with a shift-add loop, one multiplier bit per clock, under a start/busy/done handshake.
- Adds zero-sign normalisation and an optional early-exit mode.

Parameters:
- WIDTH, 4, magnitude bits per operand; the operand word is WIDTH+1 bits with the sign in the MSB.
- EARLY_EXIT, 0, when 1 the loop terminates as soon as the remaining multiplier bits are all zero.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- a  input  WIDTH+1  multiplicand: a[WIDTH] = sign, a[WIDTH-1:0] = magnitude.
- b  input  WIDTH+1  multiplier, same format as a.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- sign  output  1  product sign.
- out  output  2*WIDTH  product magnitude.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is asynchronous and active-high: reset high forces state=IDLE and busy=0, done=0, sign=0, out=0, and clears all internal registers immediately, without waiting for a clock edge.
- State machine: IDLE, RUN.
- IDLE, start=1 at edge k:
  - Latch mcand = a magnitude, zero-extended to 2*WIDTH bits.
  - Latch mplier = b magnitude.
  - Latch sgn = a[WIDTH] XOR b[WIDTH].
  - Clear acc and the bit counter; go to RUN; busy=1 from edge k.
- IDLE, start=0: hold; out and sign keep the last result.
- RUN, each edge:
  - If mplier[0]=1, acc += mcand.
  - mcand shifts left by 1, mplier shifts right by 1, counter increments.
- RUN termination:
  - EARLY_EXIT=0: terminate on the edge that processes bit WIDTH-1, i.e. edge k+WIDTH. Latency is fixed at WIDTH cycles.
  - EARLY_EXIT=1: terminate on the first RUN edge after which the shifted mplier == 0, or at counter WIDTH-1, whichever comes first. Minimum one RUN edge, so b magnitude 0 or 1 finishes at edge k+1.
- On the terminating edge:
  - out <= final acc, including the current step's add.
  - sign <= sgn, except sign <= 0 when the final acc == 0 (no negative zero).
  - done <= 1, busy <= 0, state -> IDLE.
- done is high for exactly one cycle, then deasserts; out and sign hold until the next completion.
- out and sign never change except on a terminating edge or reset.
- Width: the product of two WIDTH-bit magnitudes fits in 2*WIDTH bits, so there is no overflow. The accumulator is 2*WIDTH bits and unsigned.
- start while busy=1 is ignored; operands are not re-sampled and the current operation is unaffected.
- start=1 in the cycle where done=1 (state is already IDLE) is accepted: the new operation begins and busy rises on that edge. done falls on that edge as normal.
- a and b are sampled only at the start edge; changes to them during RUN have no effect.
- Reset during RUN aborts the operation: no done pulse, and out/sign are cleared to 0.
- Reset and start asserted together: reset wins.
- Operands with magnitude 0 are legal. The result is out=0, sign=0 regardless of the input signs.

Test Plan:
- WIDTH=4, EARLY_EXIT=0, a=5'b0_0011 (+3), b=5'b1_0101 (-5), start pulse at edge k -> busy high for edges k..k+3; done=1 after edge k+4 for one cycle; sign=1, out=8'd15.
- WIDTH=4: a=+15, b=+15 -> out=8'd225, sign=0. Also a=-15, b=-15 -> out=225, sign=0. Also a=+15, b=-1 -> out=15, sign=1.
- WIDTH=4: a=5'b1_0000 (-0), b=+7 -> out=0, sign=0. Also a=-9, b=-0 -> out=0, sign=0.
- Handshake, WIDTH=4:
  - Start 3*4; while busy, pulse start with a=+7, b=+7 -> ignored, result out=12.
  - Assert start with 2*6 in the done cycle -> accepted; busy rises immediately; next done gives out=12, sign=0.
- Reset: start 9*9 with WIDTH=4, assert reset asynchronously mid-RUN -> busy, done, sign, out go to 0 without waiting for a clock edge; no done pulse follows. Release reset, run +2 * -3 -> out=6, sign=1.
- WIDTH=8, EARLY_EXIT=1:
  - b magnitude=1 -> done one edge after start.
  - b magnitude=8'h80, a=+3 -> done after 8 edges, out=16'd384.
  - b magnitude=0 -> done after 1 edge, out=0, sign=0.

Source files
------------

// File: rtl/seq_sm_multiplier.sv
// Sequential sign-magnitude multiplier: one multiplier bit per clock,
// start/busy/done handshake, optional early exit on an exhausted multiplier.
module seq_sm_multiplier #(
  parameter int WIDTH      = 4,
  parameter int EARLY_EXIT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH:0]     a,
  input  logic [WIDTH:0]     b,
  output logic               busy,
  output logic               done,
  output logic               sign,
  output logic [2*WIDTH-1:0] out
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sgn_q, sgn_d;
  logic [PW-1:0]   out_q, out_d;
  logic            sign_q, sign_d;
  logic            done_q, done_d;

  logic [PW-1:0]    acc_sum;
  logic [WIDTH-1:0] mplier_sh;
  logic             last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
      out_q    <= '0;
      sign_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sgn_q    <= sgn_d;
      out_q    <= out_d;
      sign_q   <= sign_d;
      done_q   <= done_d;
    end
  end

  assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mplier_sh = mplier_q >> 1;

  // Early exit only when every remaining multiplier bit is zero.
  always_comb begin
    last = (cnt_q == CW'(WIDTH - 1));
    if (EARLY_EXIT != 0 && mplier_sh == '0)
      last = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sgn_d    = sgn_q;
    out_d    = out_q;
    sign_d   = sign_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = PW'(a[WIDTH-1:0]);
          mplier_d = b[WIDTH-1:0];
          sgn_d    = a[WIDTH] ^ b[WIDTH];
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_sh;
        cnt_d    = cnt_q + 1'b1;
        if (last) begin
          out_d   = acc_sum;
          sign_d  = sgn_q & (|acc_sum);
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = done_q;
    sign = sign_q;
    out  = out_q;
  end

endmodule

// File: tb/tb_seq_sm_multiplier.sv
// Randomised and directed bench for seq_sm_multiplier against an
// arithmetic reference (product, sign, latency) for two configurations.
module tb_seq_sm_multiplier;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       s4, busy4, done4, sign4;
  logic [4:0] a4, b4;
  logic [7:0] out4;

  logic        s8, busy8, done8, sign8;
  logic [8:0]  a8, b8;
  logic [15:0] out8;

  int checks = 0;
  int errors = 0;

  seq_sm_multiplier #(.WIDTH(4), .EARLY_EXIT(0)) u4 (
    .clk(clk), .reset(reset), .start(s4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sign(sign4), .out(out4)
  );

  seq_sm_multiplier #(.WIDTH(8), .EARLY_EXIT(1)) u8 (
    .clk(clk), .reset(reset), .start(s8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sign(sign8), .out(out8)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int lat8(input logic [7:0] m);
    int l = 0;
    for (int i = 0; i < 8; i++) if (m[i]) l = i + 1;
    return (l == 0) ? 1 : l;
  endfunction

  task automatic go4(input logic [4:0] av, input logic [4:0] bv,
                     input string tag);
    a4 = av; b4 = bv; s4 = 1'b1;
    @(posedge clk); #1;
    s4 = 1'b0;
    check({tag, "_busy"}, 32'(busy4), 32'd1);
    check({tag, "_done0"}, 32'(done4), 32'd0);
  endtask

  task automatic fin4(input string tag, input logic [4:0] av,
                      input logic [4:0] bv, input int lat, input bit tail);
    int n = 0;
    int ep = int'(av[3:0]) * int'(bv[3:0]);
    logic es = (av[4] ^ bv[4]) && (ep != 0);
    while (!done4 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_out"}, 32'(out4), 32'(ep));
    check({tag, "_sign"}, 32'(sign4), 32'(es));
    check({tag, "_busy0"}, 32'(busy4), 32'd0);
    if (tail) begin
      @(posedge clk); #1;
      check({tag, "_pulse"}, 32'(done4), 32'd0);
      check({tag, "_hold"}, 32'(out4), 32'(ep));
    end
  endtask

  task automatic op8(input logic [8:0] av, input logic [8:0] bv,
                     input string tag);
    int n = 0;
    int ep = int'(av[7:0]) * int'(bv[7:0]);
    logic es = (av[8] ^ bv[8]) && (ep != 0);
    a8 = av; b8 = bv; s8 = 1'b1;
    @(posedge clk); #1;
    s8 = 1'b0;
    check({tag, "_busy"}, 32'(busy8), 32'd1);
    while (!done8 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat8(bv[7:0])));
    check({tag, "_out"}, 32'(out8), 32'(ep));
    check({tag, "_sign"}, 32'(sign8), 32'(es));
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(done8), 32'd0);
  endtask

  initial begin
    int seen;
    reset = 1'b1; s4 = 0; s8 = 0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    #1;
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);
    check("rst_out", 32'(out4), 32'd0);
    check("rst_sign", 32'(sign4), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    go4(5'b0_0011, 5'b1_0101, "m3x5");
    fin4("m3x5", 5'b0_0011, 5'b1_0101, 4, 1'b1);
    go4(5'b0_1111, 5'b0_1111, "pp15");
    fin4("pp15", 5'b0_1111, 5'b0_1111, 4, 1'b1);
    go4(5'b1_1111, 5'b1_1111, "nn15");
    fin4("nn15", 5'b1_1111, 5'b1_1111, 4, 1'b1);
    go4(5'b0_1111, 5'b1_0001, "p15n1");
    fin4("p15n1", 5'b0_1111, 5'b1_0001, 4, 1'b1);
    go4(5'b1_0000, 5'b0_0111, "nz7");
    fin4("nz7", 5'b1_0000, 5'b0_0111, 4, 1'b1);
    go4(5'b1_1001, 5'b1_0000, "n9nz");
    fin4("n9nz", 5'b1_1001, 5'b1_0000, 4, 1'b1);

    go4(5'd3, 5'd4, "ign");
    a4 = 5'd7; b4 = 5'd7; s4 = 1'b1;
    @(posedge clk); #1;
    s4 = 1'b0;
    fin4("ign", 5'd3, 5'd4, 3, 1'b1);

    go4(5'd3, 5'd4, "b2b1");
    fin4("b2b1", 5'd3, 5'd4, 4, 1'b0);
    go4(5'd2, 5'd6, "b2b2");
    fin4("b2b2", 5'd2, 5'd6, 4, 1'b1);

    go4(5'd9, 5'd9, "rst");
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy4), 32'd0);
    check("arst_done", 32'(done4), 32'd0);
    check("arst_out", 32'(out4), 32'd0);
    check("arst_sign", 32'(sign4), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done4 || busy4) seen++;
    end
    check("arst_nodone", 32'(seen), 32'd0);
    go4(5'b0_0010, 5'b1_0011, "post");
    fin4("post", 5'b0_0010, 5'b1_0011, 4, 1'b1);

    for (int i = 0; i < 15; i++) begin
      logic [4:0] ra, rb;
      ra = 5'($urandom); rb = 5'($urandom);
      go4(ra, rb, "rnd4");
      fin4("rnd4", ra, rb, 4, 1'b1);
    end

    op8(9'h003, 9'h101, "e_b1");
    op8(9'h003, 9'h080, "e_b80");
    op8(9'h1A5, 9'h100, "e_b0");
    for (int i = 0; i < 25; i++) begin
      logic [8:0] ra, rb;
      ra = 9'($urandom);
      rb = 9'($urandom) >> $urandom_range(0, 8);
      op8(ra, rb, "rnd8");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
